// File: rtl/mc_datapath.sv
// Multi-cycle MIPS datapath: PC/IR/MDR/A/B/ALUOut state, 32x32 register file and ALU,
// stepped by the control word supplied each cycle by the multi-cycle controller.
module mc_datapath (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWr,
    input  logic        PCWrCond,
    input  logic        IorD,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic        IRWr,
    input  logic        MemtoReg,
    input  logic        ALUSrcA,
    input  logic        RegWr,
    input  logic        RegDst,
    input  logic [1:0]  PCSrc,
    input  logic [1:0]  ALUOp,
    input  logic [1:0]  ALUSrcB,
    input  logic [31:0] Mem_RData,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_WData,
    output logic        Mem_Rd,
    output logic        Mem_Wr,
    output logic [5:0]  OP_Code,
    output logic        Zero
);

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_mdr;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_aluout;
    logic [31:0] r_rf [32];

    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_wr_addr;
    logic [31:0] w_wr_data;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_se;
    logic [31:0] w_alu_a;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_res;
    logic [31:0] w_pc_next;
    logic        w_pc_en;
    alu_op_t     w_alu_op;

    assign w_rs      = r_ir[25:21];
    assign w_rt      = r_ir[20:16];
    assign w_wr_addr = RegDst ? r_ir[15:11] : r_ir[20:16];
    assign w_wr_data = MemtoReg ? r_mdr : r_aluout;
    assign w_rs_val  = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
    assign w_rt_val  = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];
    assign w_se      = {{16{r_ir[15]}}, r_ir[15:0]};

    assign w_alu_a = ALUSrcA ? r_a : r_pc;

    always_comb begin
        w_alu_b = r_b;
        case (ALUSrcB)
            2'b00: w_alu_b = r_b;
            2'b01: w_alu_b = 32'd4;
            2'b10: w_alu_b = w_se;
            2'b11: w_alu_b = {w_se[29:0], 2'b00};
            default: w_alu_b = r_b;
        endcase
    end

    // Unrecognised funct codes fall back to add rather than a defined trap.
    always_comb begin
        w_alu_op = ALU_ADD;
        case (ALUOp)
            2'b01: w_alu_op = ALU_SUB;
            2'b10: begin
                case (r_ir[5:0])
                    6'b100010: w_alu_op = ALU_SUB;
                    6'b100100: w_alu_op = ALU_AND;
                    6'b100101: w_alu_op = ALU_OR;
                    6'b101010: w_alu_op = ALU_SLT;
                    default:   w_alu_op = ALU_ADD;
                endcase
            end
            default: w_alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        w_alu_res = w_alu_a + w_alu_b;
        case (w_alu_op)
            ALU_ADD: w_alu_res = w_alu_a + w_alu_b;
            ALU_SUB: w_alu_res = w_alu_a - w_alu_b;
            ALU_AND: w_alu_res = w_alu_a & w_alu_b;
            ALU_OR:  w_alu_res = w_alu_a | w_alu_b;
            ALU_SLT: w_alu_res = ($signed(w_alu_a) < $signed(w_alu_b)) ? 32'd1 : 32'd0;
            default: w_alu_res = w_alu_a + w_alu_b;
        endcase
    end

    always_comb begin
        w_pc_next = w_alu_res;
        case (PCSrc)
            2'b00: w_pc_next = w_alu_res;
            2'b01: w_pc_next = r_aluout;
            2'b10: w_pc_next = {r_pc[31:28], r_ir[25:0], 2'b00};
            2'b11: w_pc_next = w_alu_res;
            default: w_pc_next = w_alu_res;
        endcase
    end

    assign Zero    = (w_alu_res == 32'd0);
    assign w_pc_en = PCWr | (PCWrCond & Zero);

    // A/B read the register file before this edge's write lands: no bypass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= '0;
            r_ir     <= '0;
            r_mdr    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            if (w_pc_en) begin
                r_pc <= w_pc_next;
            end
            if (IRWr) begin
                r_ir <= Mem_RData;
            end
            r_mdr    <= Mem_RData;
            r_a      <= w_rs_val;
            r_b      <= w_rt_val;
            r_aluout <= w_alu_res;
            if (RegWr && (w_wr_addr != 5'd0)) begin
                r_rf[w_wr_addr] <= w_wr_data;
            end
        end
    end

    assign Mem_Addr  = IorD ? r_aluout : r_pc;
    assign Mem_WData = r_b;
    assign Mem_Rd    = MemRd;
    assign Mem_Wr    = MemWr;
    assign OP_Code   = r_ir[31:26];

endmodule

// File: doc/mc_datapath.md
# mc_datapath

Multi-cycle MIPS datapath driven by the multi-cycle control unit. It holds the architectural and inter-cycle state (PC, IR, MDR, A, B, ALUOut, 32×32 register file) and applies the per-cycle control word. It returns OP_Code and Zero to the controller and drives the unified instruction/data memory port.

## Interface
- No parameters; all datapath widths are fixed at 32 bits. The register file has 32 entries.
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, MemtoReg, ALUSrcA, RegWr, RegDst  in  1 each  control word bits
- PCSrc, ALUOp, ALUSrcB  in  2 each  control word fields
- Mem_RData  in  32  memory read data, combinational (valid in the same cycle as Mem_Addr)
- Mem_Addr  out  32  IorD ? ALUOut : PC
- Mem_WData  out  32  B register
- Mem_Rd, Mem_Wr  out  1  MemRd/MemWr passed through combinationally
- OP_Code  out  6  IR[31:26]
- Zero  out  1  (ALU result == 0), combinational

## Operation
- Sign-extended immediate: SE = {{16{IR[15]}}, IR[15:0]}.
- ALU A operand:
  - ALUSrcA=0 selects PC.
  - ALUSrcA=1 selects A.
- ALU B operand:
  - ALUSrcB=00 selects B.
  - 01 selects constant 4.
  - 10 selects SE.
  - 11 selects SE<<2.
- ALU control:
  - ALUOp=00: add.
  - 01: subtract.
  - 10: decode IR[5:0]:
    - 100000 → add
    - 100010 → sub
    - 100100 → and
    - 100101 → or
    - 101010 → slt (signed, result 1/0)
    - any other funct → add
  - 11: add.
- Arithmetic is 32-bit modulo, with no overflow trap or flag.
- PC next value:
  - PCSrc=00 selects the combinational ALU result.
  - 01 selects ALUOut.
  - 10 selects {PC[31:28], IR[25:0], 2'b00}.
  - 11 selects the ALU result.
- PC write enable = PCWr | (PCWrCond & Zero).
- IR loads Mem_RData when IRWr=1 and otherwise holds.
- These load unconditionally every cycle:
  - MDR ← Mem_RData
  - A ← Reg[IR[25:21]]
  - B ← Reg[IR[20:16]]
  - ALUOut ← ALU result
- Register write:
  - Destination: RegDst ? IR[15:11] : IR[20:16].
  - Data: MemtoReg ? MDR : ALUOut.
  - Performed on the edge when RegWr=1.
- Register 0 always reads 0; writes to it are discarded.
- Reads are asynchronous. A and B capture the pre-write value on the edge where a write to the same register occurs. There is no bypass.

## Timing
- On reset assertion, immediately and asynchronously:
  - PC, IR, MDR, A, B, ALUOut and all 32 registers clear to 0.
  - Resulting outputs: Mem_Addr=0, OP_Code=0, Mem_WData=0.
  - Zero then follows the control inputs.
- Reset applied mid-instruction abandons the instruction with no partial writes retained. The first edge after deassertion behaves as a normal cycle.
- Fetch cycle (PCWr=1, IRWr=1, MemRd=1, IorD=0, ALUSrcA=0, ALUSrcB=01, PCSrc=00): at the edge, IR←mem[PC] and PC←PC+4 together.
- Simultaneous IRWr and PC update both use pre-edge values. Mem_Addr is taken from the old PC.
- The branch cycle (PCWrCond=1, ALUOp=01, ALUSrcA=1, PCSrc=01) uses the ALUOut computed in the decode cycle as the target.
  - PC changes only if A==B.
  - If A≠B, PC holds.
- Jump target uses PC[31:28] of the already-incremented PC.
- Mem_Rd, Mem_Wr, Mem_Addr, Mem_WData and Zero are combinational from the inputs and state. There is zero added latency.
- A register write is visible in A/B one edge after RegWr.

## Test plan
- Reset test:
  - Stimulus: assert reset mid-cycle, with IR and PC previously nonzero.
  - Required: PC=0, OP_Code=0 and Mem_Addr=0 immediately, without waiting for a clock edge.
  - Required: Reg[1..31] read 0.
- Fetch + R-type add:
  - Setup: preload via lw sequences so that Reg[8]=5 and Reg[9]=7.
  - Stimulus: Mem_RData=0x01095020 (add $10,$8,$9), driven through states fetch/decode/execute/writeback.
  - Required: Reg[10]=12, PC=4.
- lw/sw round trip:
  - Stimulus: sw $9,8($8) with Reg[8]=0x100.
  - Required: Mem_Addr=0x108, Mem_WData=7, Mem_Wr=1 in the write cycle.
  - Stimulus: lw $11,8($8) with Mem_RData=0xDEADBEEF at address 0x108.
  - Required: Reg[11]=0xDEADBEEF.
- beq taken and not taken, at PC=0x40 with offset 3:
  - Equal operands → PC=0x50.
  - Unequal operands → PC=0x44.
- Jump:
  - Stimulus: IR=0x08000010 at PC=0x40.
  - Required: PC=0x00000040 after the jump cycle; target = {0x0,0x10,2'b00}.
- $0 protection and slt:
  - Stimulus: add $0,$8,$9.
  - Required: Reg[0] stays 0.
  - Stimulus: slt with Reg[8]=0xFFFFFFFF and Reg[9]=1.
  - Required: result 1.
